cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Clocked arbiter that shares the Tomasulo common data bus (CDB) among the five completing units: add, logic, mul, load, store.
- Sits between the functional-unit/reservation-station completion outputs and the CDB consumers: reservation stations, register status and ROB.
- Grants exactly one requester per cycle with round-robin priority and broadcasts that requester's tag and result as a registered, single-cycle CDB pulse.
- A flush input aborts pending broadcasts on mispredict.

Parameters:
- N_REQ, 5, number of requesters; index 0 add, 1 logic, 2 mul, 3 load, 4 store.
- TAG_W, 5, reservation-station tag width.
- DATA_W, 32, result width.
- SRC_W, 3, width of source index output; must satisfy 2^SRC_W >= N_REQ.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- flush  in  1  synchronous flush; kills the grant this cycle and the pending broadcast.
- req_valid  in  N_REQ  per-requester completion request.
- req_tag  in  N_REQ*TAG_W  packed tags; requester i occupies bits [i*TAG_W +: TAG_W].
- req_data  in  N_REQ*DATA_W  packed results; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  N_REQ  one-hot or zero grant; combinational.
- cdb_valid  out  1  registered broadcast strobe.
- cdb_tag  out  TAG_W  registered broadcast tag.
- cdb_data  out  DATA_W  registered broadcast result.
- cdb_src  out  SRC_W  index of the granted requester for the current broadcast.

Behaviour:
Reset:
- rst_n=0 at a rising edge clears cdb_valid, cdb_tag, cdb_data, cdb_src and the round-robin pointer ptr to 0.
- req_ready is forced to 0 while rst_n=0.
- Reset asserted mid-stream drops any in-flight broadcast; no partial pulse appears.

Handshake:
- A transfer occurs on requester i when req_valid[i] && req_ready[i] at a rising edge.
- A requester holds req_valid, tag and data stable until its transfer completes.
- Deasserting req_valid before a grant is legal; the request is simply withdrawn.

Arbitration (combinational):
- Search req_valid starting at index ptr, ascending, wrapping from N_REQ-1 to 0.
- The first set bit gets req_ready=1; all other ready bits are 0.
- No valid request, flush=1 or rst_n=0 gives req_ready=0.

Pointer:
- After a transfer from requester g, ptr <= (g+1) mod N_REQ.
- With no transfer, ptr holds its value.
- flush does not move ptr.

Output register:
- On a transfer: cdb_valid<=1, cdb_tag<=req_tag[g], cdb_data<=req_data[g], cdb_src<=g.
- With no transfer: cdb_valid<=0; tag, data and src hold their previous values.
- Latency: grant in cycle N gives the broadcast visible in cycle N+1 for exactly one cycle.
- Back-to-back grants give consecutive cdb_valid cycles, so throughput is one broadcast per cycle.

Flush:
- flush=1 at an edge sets cdb_valid<=0, including cancelling the broadcast that would otherwise launch.
- No req_ready is asserted during flush, so requesters keep their requests unless they drop them.

Fairness:
- Each continuously valid requester is granted within N_REQ cycles.
- Starvation is impossible.

Simultaneous events:
- Priority order is rst_n, then flush, then normal arbitration.

Test Plan:
1. After reset, req_valid=5'b00100, tag 5'd9, data 32'hDEAD_BEEF:
   - req_ready=5'b00100 in the same cycle.
   - Next cycle cdb_valid=1, tag 9, data DEADBEEF, src 2.
   - ptr becomes 3.
   - Following cycle cdb_valid=0.
2. All five valid from reset and held until granted:
   - Grants in order 0,1,2,3,4 on consecutive cycles.
   - cdb_valid high for 5 consecutive cycles with src 0..4 and matching tags.
3. Round-robin wrap: after granting 2 (ptr=3), req_valid=5'b00011 → grant order 0 then 1.
4. Round-robin skip: after granting 2 (ptr=3), req_valid=5'b01001 → grant order 3 then 0.
5. Assert flush together with req_valid=5'b10000:
   - req_ready=0.
   - cdb_valid=0 next cycle.
   - ptr unchanged.
   - After flush drops, store is granted and broadcast one cycle later.
6. Reset mid-operation: pull rst_n low in the cycle a grant would occur → next cycle all outputs 0, ptr=0, no broadcast.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// Completion-bus bundle between functional units and the CDB arbiter.
// Requesters drive req_*; the arbiter returns req_ready and the cdb_* broadcast.
interface cdb_arbiter_if #(
  parameter int N_REQ  = 5,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32,
  parameter int SRC_W  = 3
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*TAG_W-1:0]  req_tag;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    cdb_valid;
  logic [TAG_W-1:0]        cdb_tag;
  logic [DATA_W-1:0]       cdb_data;
  logic [SRC_W-1:0]        cdb_src;

  modport master (
    output req_valid, req_tag, req_data,
    input  req_ready,
    input  cdb_valid, cdb_tag, cdb_data, cdb_src
  );

  modport slave (
    input  req_valid, req_tag, req_data,
    output req_ready,
    output cdb_valid, cdb_tag, cdb_data, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin common data bus arbiter with registered single-cycle broadcast.
// Flush suppresses the grant; reset clears the pointer and broadcast register.
module cdb_arbiter #(
  parameter int N_REQ  = 5,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32,
  parameter int SRC_W  = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  cdb_arbiter_if.slave bus
);
  logic [SRC_W-1:0]  r_ptr;
  logic              r_valid;
  logic [TAG_W-1:0]  r_tag;
  logic [DATA_W-1:0] r_data;
  logic [SRC_W-1:0]  r_src;

  logic [N_REQ-1:0]  w_grant;
  logic [SRC_W-1:0]  w_gidx;
  logic [SRC_W-1:0]  w_ptr_nxt;
  logic              w_xfer;
  int                w_idx;

  // Rotating search from r_ptr; first valid requester wins.
  always_comb begin
    w_grant = '0;
    w_gidx  = '0;
    w_xfer  = 1'b0;
    w_idx   = 0;
    if (rst_n && !flush) begin
      for (int k = 0; k < N_REQ; k++) begin
        w_idx = int'(r_ptr) + k;
        if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
        if (!w_xfer && bus.req_valid[w_idx]) begin
          w_xfer         = 1'b1;
          w_grant[w_idx] = 1'b1;
          w_gidx         = SRC_W'(w_idx);
        end
      end
    end
  end

  always_comb begin
    if (w_gidx == SRC_W'(N_REQ - 1)) w_ptr_nxt = '0;
    else                             w_ptr_nxt = w_gidx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
      r_src   <= '0;
    end else begin
      r_valid <= w_xfer;
      if (w_xfer) begin
        r_ptr  <= w_ptr_nxt;
        r_tag  <= bus.req_tag[w_gidx*TAG_W +: TAG_W];
        r_data <= bus.req_data[w_gidx*DATA_W +: DATA_W];
        r_src  <= w_gidx;
      end
    end
  end

  assign bus.req_ready = w_grant;
  assign bus.cdb_valid = r_valid;
  assign bus.cdb_tag   = r_tag;
  assign bus.cdb_data  = r_data;
  assign bus.cdb_src   = r_src;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with a broadcast scoreboard.
// Stimulus queues expected broadcasts; a negedge monitor pops and compares.
module tb_cdb_arbiter;
  localparam int N = 5;
  localparam int TW = 5;
  localparam int DW = 32;
  localparam int SW = 3;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    logic [SW-1:0] src;
  } bc_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int checks = 0;
  int errors = 0;
  bc_t exp_q[$];
  logic [TW-1:0] tags [N];
  logic [DW-1:0] datas [N];

  cdb_arbiter_if #(.N_REQ(N), .TAG_W(TW), .DATA_W(DW), .SRC_W(SW)) bus ();

  cdb_arbiter #(.N_REQ(N), .TAG_W(TW), .DATA_W(DW), .SRC_W(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at posedge+1: apply inputs, check ready, queue broadcast, advance.
  task automatic cyc(input string nm, input logic [N-1:0] v,
                     input logic [N-1:0] rdy, input logic fl, input logic rn);
    bc_t e;
    bus.req_valid = v;
    flush = fl;
    rst_n = rn;
    #2;
    chk(nm, 64'(bus.req_ready), 64'(rdy));
    for (int i = 0; i < N; i++) begin
      if (rdy[i]) begin
        e.tag  = tags[i];
        e.data = datas[i];
        e.src  = SW'(i);
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_valid"}, 64'(bus.cdb_valid), 64'd0);
  endtask

  task automatic chk_zero(input string nm);
    chk_idle(nm);
    chk({nm, "_tag"},  64'(bus.cdb_tag),  64'd0);
    chk({nm, "_data"}, 64'(bus.cdb_data), 64'd0);
    chk({nm, "_src"},  64'(bus.cdb_src),  64'd0);
  endtask

  // Monitor: every broadcast must match the oldest queued expectation.
  initial begin
    bc_t a;
    bc_t e;
    forever begin
      @(negedge clk);
      if (bus.cdb_valid === 1'b1) begin
        a.tag  = bus.cdb_tag;
        a.data = bus.cdb_data;
        a.src  = bus.cdb_src;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_bcast: got %0h expected none", a);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            errors++;
            $display("FAIL bcast: got tag %0d data %0h src %0d expected tag %0d data %0h src %0d",
                     a.tag, a.data, a.src, e.tag, e.data, e.src);
          end
        end
      end
    end
  end

  initial begin
    tags[0] = 5'd7;  datas[0] = 32'h0000_A0A0;
    tags[1] = 5'd8;  datas[1] = 32'h1111_1111;
    tags[2] = 5'd9;  datas[2] = 32'hDEAD_BEEF;
    tags[3] = 5'd10; datas[3] = 32'h3333_CAFE;
    tags[4] = 5'd11; datas[4] = 32'h4444_F00D;
    for (int i = 0; i < N; i++) begin
      bus.req_tag[i*TW +: TW]  = tags[i];
      bus.req_data[i*DW +: DW] = datas[i];
    end
    bus.req_valid = '0;
    @(posedge clk);
    #1;

    // Reset: ready forced low even with all requesting
    cyc("rst_rdy0", 5'b11111, 5'b00000, 1'b0, 1'b0);
    cyc("rst_rdy1", 5'b11111, 5'b00000, 1'b0, 1'b0);
    chk_zero("rst");

    // Test 1: single request from mul
    cyc("t1_grant", 5'b00100, 5'b00100, 1'b0, 1'b1);
    chk("t1_valid", 64'(bus.cdb_valid), 64'd1);
    cyc("t1_idle", 5'b00000, 5'b00000, 1'b0, 1'b1);
    chk_idle("t1_after");

    // Test 2: all five from reset, dropped one at a time as granted
    cyc("t2_rst", 5'b00000, 5'b00000, 1'b0, 1'b0);
    cyc("t2_g0", 5'b11111, 5'b00001, 1'b0, 1'b1);
    cyc("t2_g1", 5'b11110, 5'b00010, 1'b0, 1'b1);
    cyc("t2_g2", 5'b11100, 5'b00100, 1'b0, 1'b1);
    cyc("t2_g3", 5'b11000, 5'b01000, 1'b0, 1'b1);
    cyc("t2_g4", 5'b10000, 5'b10000, 1'b0, 1'b1);
    chk("t2_last_valid", 64'(bus.cdb_valid), 64'd1);

    // Test 3: ptr=3, requests 0 and 1 -> wrap to 0 then 1
    cyc("t3_g2", 5'b00100, 5'b00100, 1'b0, 1'b1);
    cyc("t3_g0", 5'b00011, 5'b00001, 1'b0, 1'b1);
    cyc("t3_g1", 5'b00010, 5'b00010, 1'b0, 1'b1);

    // Test 4: ptr=3, requests 0 and 3 -> 3 then 0
    cyc("t4_g2", 5'b00100, 5'b00100, 1'b0, 1'b1);
    cyc("t4_g3", 5'b01001, 5'b01000, 1'b0, 1'b1);
    cyc("t4_g0", 5'b00001, 5'b00001, 1'b0, 1'b1);

    // Test 5: flush with store pending (ptr=1)
    cyc("t5_flush", 5'b10000, 5'b00000, 1'b1, 1'b1);
    chk_idle("t5_flushed");
    cyc("t5_g4", 5'b10000, 5'b10000, 1'b0, 1'b1);
    chk("t5_valid", 64'(bus.cdb_valid), 64'd1);
    // ptr now 0; flush must not advance it
    cyc("t5_flush2", 5'b00011, 5'b00000, 1'b1, 1'b1);
    chk_idle("t5_flushed2");
    cyc("t5_g0", 5'b00011, 5'b00001, 1'b0, 1'b1);

    // Test 6: reset in the cycle a grant would happen (ptr=1)
    cyc("t6_rst", 5'b00110, 5'b00000, 1'b0, 1'b0);
    chk_zero("t6");
    cyc("t6_g0", 5'b00011, 5'b00001, 1'b0, 1'b1);

    cyc("drain0", 5'b00000, 5'b00000, 1'b0, 1'b1);
    cyc("drain1", 5'b00000, 5'b00000, 1'b0, 1'b1);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
